// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : Oversampling UART receiver. Synchronizes the serial line,
//             detects a start bit, reassembles an LSB-first frame, checks
//             optional parity and the stop bit, and emits one-cycle strobes.
//  Ports    : clk, rst       - clock, synchronous active-high reset
//             rx_in          - serial line (idle high, asynchronous)
//             prescale[5:0]  - oversampling ratio (8, 16 or 32)
//             par_en/par_typ - parity enable / 0 even, 1 odd
//             p_data         - last good byte (held between good frames)
//             data_valid     - one-cycle strobe, p_data updated
//             par_err        - one-cycle strobe, parity mismatch
//             stp_err        - one-cycle strobe, stop bit sampled low
//  Build    : define UART_RX_GLITCH_FILTER_EN for 2-of-3 majority sampling;
//             undefined gives a single sample at mid-bit.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [5:0]            prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    logic                  r_sync1;
    logic                  r_rx_s;
    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic [5:0]            r_tick;
    logic [CNT_W-1:0]      r_bit;
    logic [5:0]            r_p;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic                  r_par_bad;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [5:0]            w_half;
    logic                  w_last_tick;
    logic                  w_bit_last;
    logic                  w_start_det;
    logic                  w_bit;
    logic                  w_dv_nxt;
    logic                  w_pe_nxt;
    logic                  w_se_nxt;

    assign w_half      = {1'b0, r_p[5:1]};
    assign w_last_tick = (r_tick == (r_p - 6'd1));
    assign w_bit_last  = (r_bit == CNT_W'(DATA_WIDTH - 1));
    assign w_start_det = (r_state == S_IDLE) && !r_rx_s;

    // Two-flop synchronizer; resets high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= rx_in;
            r_rx_s  <= r_sync1;
        end
    end

`ifdef UART_RX_GLITCH_FILTER_EN
    // Three samples around mid-bit; the decision is the 2-of-3 majority.
    logic [2:0] r_samp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_samp <= 3'b111;
        end else if ((r_tick == (w_half - 6'd1)) || (r_tick == w_half) ||
                     (r_tick == (w_half + 6'd1))) begin
            r_samp <= {r_samp[1:0], r_rx_s};
        end
    end

    assign w_bit = (r_samp[0] & r_samp[1]) | (r_samp[1] & r_samp[2]) |
                   (r_samp[0] & r_samp[2]);
`else
    logic r_samp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_samp <= 1'b1;
        end else if (r_tick == w_half) begin
            r_samp <= r_rx_s;
        end
    end

    assign w_bit = r_samp;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and strobe decode; strobes are registered one cycle later,
    // which places them on the IDLE cycle following the stop bit.
    always_comb begin
        w_state_nxt = r_state;
        w_dv_nxt    = 1'b0;
        w_pe_nxt    = 1'b0;
        w_se_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_rx_s) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_last_tick) begin
                    w_state_nxt = w_bit ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_last_tick && w_bit_last) begin
                    w_state_nxt = r_par_en ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_last_tick) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_last_tick) begin
                    if (!w_bit) begin
                        w_se_nxt    = 1'b1;
                        w_pe_nxt    = r_par_bad;
                        w_state_nxt = S_BREAK;
                    end else if (r_par_bad) begin
                        w_pe_nxt    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_dv_nxt    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_BREAK: begin
                if (r_rx_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick     <= 6'd0;
            r_bit      <= '0;
            r_p        <= 6'd16;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_par_bad  <= 1'b0;
            r_shift    <= '0;
            p_data     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            // The start-detect cycle is tick 0, so the counter leaves IDLE at 1.
            if (r_state == S_IDLE) begin
                r_tick <= w_start_det ? 6'd1 : 6'd0;
            end else if (r_state == S_BREAK) begin
                r_tick <= 6'd0;
            end else if (w_last_tick) begin
                r_tick <= 6'd0;
            end else begin
                r_tick <= r_tick + 6'd1;
            end

            // Frame configuration is frozen for the whole frame.
            if (w_start_det) begin
                r_p       <= prescale;
                r_par_en  <= par_en;
                r_par_typ <= par_typ;
                r_par_bad <= 1'b0;
                r_bit     <= '0;
            end

            if ((r_state == S_DATA) && w_last_tick) begin
                r_shift <= {w_bit, r_shift[DATA_WIDTH-1:1]};
                r_bit   <= r_bit + CNT_W'(1);
            end

            if ((r_state == S_PARITY) && w_last_tick) begin
                r_par_bad <= (w_bit != ((^r_shift) ^ r_par_typ));
            end

            data_valid <= w_dv_nxt;
            par_err    <= w_pe_nxt;
            stp_err    <= w_se_nxt;
            if (w_dv_nxt) begin
                p_data <= r_shift;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Self-checking bench for uart_rx. Frames are described at bit
//             level; the expected strobe kind, cycle and byte of each frame
//             are derived from the frame contents and stored by cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int DW = 8;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          rx_in    = 1'b1;
    logic [5:0]    prescale = 6'd8;
    logic          par_en   = 1'b0;
    logic          par_typ  = 1'b0;
    logic [DW-1:0] p_data;
    logic          data_valid;
    logic          par_err;
    logic          stp_err;

    uart_rx #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .prescale   (prescale),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Expected strobes keyed by cycle: bit2 data_valid, bit1 par_err, bit0 stp_err
    int            exp_mask[int];
    logic [DW-1:0] exp_data[int];
    logic [DW-1:0] model_pdata = '0;
    int            reset_cyc   = -1;
    bit            active      = 1'b0;
    int            cmp_m;
    int            dv_cnt = 0, pe_cnt = 0, se_cnt = 0;
    int            last_dv = -1, last_pe = -1, last_se = -1;
    int            dv_cycles[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // Per-cycle comparison against the frame-level model
    always @(negedge clk) begin
        if (active) begin
            if (cyc == reset_cyc) model_pdata = '0;
            cmp_m = exp_mask.exists(cyc) ? exp_mask[cyc] : 0;
            if (cmp_m[2]) model_pdata = exp_data[cyc];
            chk("strobes", {29'd0, data_valid, par_err, stp_err}, cmp_m);
            chk("p_data", {24'd0, p_data}, {24'd0, model_pdata});
            if (data_valid) begin dv_cnt++; last_dv = cyc; dv_cycles.push_back(cyc); end
            if (par_err)    begin pe_cnt++; last_pe = cyc; end
            if (stp_err)    begin se_cnt++; last_se = cyc; end
        end
    end

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            rx_in = 1'b1;
        end
    endtask

    function automatic logic [5:0] rand_p();
        int r;
        r = $urandom_range(0, 2);
        return (r == 0) ? 6'd8 : ((r == 1) ? 6'd16 : 6'd32);
    endfunction

    // Drives one frame; s returns the cycle in which the start bit was driven.
    task automatic send_frame(input logic [DW-1:0] d, input logic [5:0] p,
                              input logic pen, input logic ptyp,
                              input logic bad_par, input logic stop_bit,
                              input int glitch_at, input bit scramble,
                              output int s);
        int          n;
        int          pi;
        int          m;
        int          ev;
        logic [10:0] bits;
        logic        pbit;
        n    = pen ? 11 : 10;
        pi   = int'(p);
        pbit = (^d) ^ ptyp ^ bad_par;
        bits = pen ? {stop_bit, pbit, d, 1'b0} : {1'b0, stop_bit, d, 1'b0};
        if (!stop_bit)          m = 1 | ((pen && bad_par) ? 2 : 0);
        else if (pen && bad_par) m = 2;
        else                    m = 4;
        @(posedge clk); #1;
        s        = cyc;
        prescale = p;
        par_en   = pen;
        par_typ  = ptyp;
        ev       = s + 2 + n * pi;
        exp_mask[ev] = m;
        exp_data[ev] = d;
        for (int i = 0; i < n * pi; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            rx_in = bits[i / pi];
            if (i == glitch_at) rx_in = ~rx_in;
            if (scramble && i == pi + 1) begin
                prescale = rand_p();
                par_en   = 1'($urandom);
                par_typ  = 1'($urandom);
            end
        end
    endtask

    int            s, s2;
    int            dv0, pe0, se0;
    logic [10:0]   abort_bits;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_p_data", {24'd0, p_data}, 32'd0);
        chk("reset_strobes", {29'd0, data_valid, par_err, stp_err}, 32'd0);
        rst    = 1'b0;
        active = 1'b1;
        idle(5);

        // 0xA5, P=8, no parity: strobe 82 cycles after the start bit
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        send_frame(8'hA5, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0, s);
        idle(5);
        chk("a5_count", dv_cnt - dv0, 1);
        chk("a5_latency", last_dv - s, 82);
        chk("a5_data", {24'd0, p_data}, 32'h0000_00A5);
        chk("a5_no_err", (pe_cnt - pe0) + (se_cnt - se0), 0);

        // 0x3C, P=16, even parity: good, then bad parity bit
        send_frame(8'h3C, 6'd16, 1'b1, 1'b0, 1'b0, 1'b1, -1, 1'b0, s);
        idle(5);
        chk("par_good_latency", last_dv - s, 178);
        chk("par_good_data", {24'd0, p_data}, 32'h0000_003C);
        pe0 = pe_cnt;
        send_frame(8'h3C, 6'd16, 1'b1, 1'b0, 1'b1, 1'b1, -1, 1'b0, s);
        idle(5);
        chk("par_bad_count", pe_cnt - pe0, 1);
        chk("par_bad_latency", last_pe - s, 178);
        chk("par_bad_hold", {24'd0, p_data}, 32'h0000_003C);

        // Short low glitch: no strobe of any kind
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        @(posedge clk); #1;
        prescale = 6'd8; par_en = 1'b0;
        rx_in = 1'b0;
        idle(0);
        @(posedge clk); #1; rx_in = 1'b0;
        @(posedge clk); #1; rx_in = 1'b0;
        idle(20);
        chk("glitch_no_strobe", (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0), 0);

`ifdef UART_RX_GLITCH_FILTER_EN
        // One-cycle low pulse on the mid-bit sample of data bit 2
        send_frame(8'hFF, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 3 * 8 + 4, 1'b0, s);
        idle(5);
        chk("filter_data", {24'd0, p_data}, 32'h0000_00FF);
`endif

        // Line held low for 200 cycles: a single stop error
        dv0 = dv_cnt; se0 = se_cnt;
        @(posedge clk); #1;
        s = cyc; prescale = 6'd8; par_en = 1'b0; rx_in = 1'b0;
        exp_mask[s + 82] = 1;
        for (int k = 1; k < 200; k++) begin @(posedge clk); #1; rx_in = 1'b0; end
        idle(10);
        chk("break_count", se_cnt - se0, 1);
        chk("break_latency", last_se - s, 82);
        chk("break_no_dv", dv_cnt - dv0, 0);
        send_frame(8'h96, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0, s);
        idle(5);
        chk("after_break_data", {24'd0, p_data}, 32'h0000_0096);

        // Back-to-back frames with no idle gap
        send_frame(8'h01, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0, s);
        send_frame(8'hFE, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0, s2);
        idle(5);
        chk("b2b_first", dv_cycles[dv_cycles.size() - 2] - s, 82);
        chk("b2b_second", dv_cycles[dv_cycles.size() - 1] - s, 162);
        chk("b2b_data", {24'd0, p_data}, 32'h0000_00FE);

        // Reset 40 cycles into a frame
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        abort_bits = {2'b11, 8'h33, 1'b0};
        @(posedge clk); #1;
        prescale = 6'd8; par_en = 1'b0;
        rx_in = abort_bits[0];
        for (int i = 1; i < 40; i++) begin @(posedge clk); #1; rx_in = abort_bits[i / 8]; end
        @(posedge clk); #1;
        rst = 1'b1; rx_in = 1'b1; reset_cyc = cyc + 1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_p_data", {24'd0, p_data}, 32'd0);
        chk("rst_strobes", {29'd0, data_valid, par_err, stp_err}, 32'd0);
        idle(100);
        chk("rst_no_strobe", (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0), 0);
        send_frame(8'h55, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0, s);
        idle(5);
        chk("rst_next_data", {24'd0, p_data}, 32'h0000_0055);

        // Randomized frames, configuration scrambled mid-frame
        for (int f = 0; f < 40; f++) begin
            logic [DW-1:0] d;
            logic          pen, ptyp, bad, stp;
            d    = DW'($urandom);
            pen  = 1'($urandom);
            ptyp = 1'($urandom);
            bad  = ($urandom_range(0, 3) == 0);
            stp  = ($urandom_range(0, 7) != 0);
            send_frame(d, rand_p(), pen, ptyp, bad, stp, -1, 1'b1, s);
            if (!stp) idle(4);
            else      idle($urandom_range(0, 3));
        end
        idle(400);

        active = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
